// File: rtl/rv32i_decode_buffer_pkg.sv
// Shared RV32I decode definitions: base opcodes, format classes, buffer and
// decoded-instruction payloads, and a base-opcode membership helper.
package RV32I_definitions;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    // One raw fetch entry held in the buffer.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } raw_inst_t;

    // Everything presented to the execute stage.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            illegal;
    } decoded_inst_t;

    // True for the eleven RV32I base opcodes (bits [1:0] are part of the match).
    function automatic logic is_base_opcode(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decode_buffer_if.sv
// Fetch-side and decode-side handshake bundle for rv32i_decode_buffer.
//   master: fetch + execute side (drives if_*, id_ready)
//   slave : the decode buffer (drives if_ready, id_*)
interface rv32i_decode_buffer_if;
    import RV32I_definitions::*;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instruction;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;
    logic [4:0]      id_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [XLEN-1:0] id_imm;
    fmt_t            id_fmt;
    logic            id_illegal;

    modport master (
        output if_valid, if_pc, if_instruction, id_ready,
        input  if_ready, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_funct3, id_funct7, id_imm, id_fmt, id_illegal
    );

    modport slave (
        input  if_valid, if_pc, if_instruction, id_ready,
        output if_ready, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_funct3, id_funct7, id_imm, id_fmt, id_illegal
    );

endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I format classifier and immediate extractor.
//   inst      in  32 : raw instruction word
//   fmt_c     out    : format class
//   imm_c     out 32 : sign-extended immediate (0 for R)
//   illegal_c out    : unknown opcode (only with DECODE_ILLEGAL_CHECK_EN)
// Macro DECODE_ILLEGAL_CHECK_EN: flag non-base opcodes as illegal with fmt I,
// imm 0; otherwise unknown opcodes decode as plain I format.
module rv32i_imm_gen
    import RV32I_definitions::*;
(
    input  logic [XLEN-1:0] inst,
    output fmt_t            fmt_c,
    output logic [XLEN-1:0] imm_c,
    output logic            illegal_c
);

    // Opcode to format class; anything unrecognised falls back to I.
    always_comb begin
        fmt_c = FMT_I;
        case (inst[6:0])
            OPC_OP:               fmt_c = FMT_R;
            OPC_STORE:            fmt_c = FMT_S;
            OPC_BRANCH:           fmt_c = FMT_B;
            OPC_LUI, OPC_AUIPC:   fmt_c = FMT_U;
            OPC_JAL:              fmt_c = FMT_J;
            default:              fmt_c = FMT_I;
        endcase

        imm_c = '0;
        case (fmt_c)
            FMT_I: imm_c = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            FMT_U: imm_c = {inst[31:12], 12'b0};
            FMT_J: imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm_c = '0;
        endcase

`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal_c = !is_base_opcode(inst[6:0]);
        if (illegal_c) begin
            fmt_c = FMT_I;
            imm_c = '0;
        end
`else
        illegal_c = 1'b0;
`endif
    end

endmodule

// File: rtl/rv32i_decode_buffer.sv
// ToastCore decode front end: 2-entry raw instruction FIFO feeding a
// registered decode output stage.
//   Clk, Reset : clock, synchronous active-high reset
//   flush      : drop buffered and output-stage instructions
//   bus        : slave side of rv32i_decode_buffer_if (fetch in, decode out)
// Macro DECODE_ILLEGAL_CHECK_EN (in rv32i_imm_gen) enables id_illegal.
module rv32i_decode_buffer
    import RV32I_definitions::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 flush,
    rv32i_decode_buffer_if.slave bus
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    raw_inst_t      mem_q [BUF_DEPTH];
    raw_inst_t      mem_d [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    decoded_inst_t    out_q, out_d;

    raw_inst_t        head;
    fmt_t             head_fmt;
    logic [XLEN-1:0]  head_imm;
    logic             head_illegal;
    logic             push, pop;

    // Acceptance depends only on registered occupancy, never on id_ready.
    assign bus.if_ready = !Reset && (count_q < CNT_W'(BUF_DEPTH));
    assign head         = mem_q[rd_ptr_q];

    rv32i_imm_gen u_imm_gen (
        .inst      (head.inst),
        .fmt_c     (head_fmt),
        .imm_c     (head_imm),
        .illegal_c (head_illegal)
    );

    // FIFO bookkeeping and output-stage load; flush overrides all of it.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        push        = bus.if_valid && bus.if_ready;
        pop         = (count_q != '0) && (!out_valid_q || bus.id_ready);

        if (bus.id_ready) begin
            out_valid_d = 1'b0;
        end
        if (pop) begin
            out_d.pc      = head.pc;
            out_d.opcode  = head.inst[6:0];
            out_d.rd      = head.inst[11:7];
            out_d.rs1     = head.inst[19:15];
            out_d.rs2     = head.inst[24:20];
            out_d.funct3  = head.inst[14:12];
            out_d.funct7  = head.inst[31:25];
            out_d.imm     = head_imm;
            out_d.fmt     = head_fmt;
            out_d.illegal = head_illegal;
            out_valid_d   = 1'b1;
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: bus.if_pc, inst: bus.if_instruction};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (flush) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_d       = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.id_valid   = out_valid_q;
    assign bus.id_pc      = out_q.pc;
    assign bus.id_opcode  = out_q.opcode;
    assign bus.id_rd      = out_q.rd;
    assign bus.id_rs1     = out_q.rs1;
    assign bus.id_rs2     = out_q.rs2;
    assign bus.id_funct3  = out_q.funct3;
    assign bus.id_funct7  = out_q.funct7;
    assign bus.id_imm     = out_q.imm;
    assign bus.id_fmt     = out_q.fmt;
    assign bus.id_illegal = out_q.illegal;

endmodule
